// File: rtl/reg_file_operand_if.sv
// Operand register file bus: write controls in, two combinational operand reads out.
interface reg_file_operand_if #(parameter int NBits = 8);
  logic [NBits-1:0] I;
  logic [1:0]       FunSel;
  logic [3:0]       RSel;
  logic [3:0]       TSel;
  logic [2:0]       OutASel;
  logic [2:0]       OutBSel;
  logic [NBits-1:0] OutA;
  logic [NBits-1:0] OutB;

  modport master (output I, FunSel, RSel, TSel, OutASel, OutBSel,
                  input  OutA, OutB);
  modport slave  (input  I, FunSel, RSel, TSel, OutASel, OutBSel,
                  output OutA, OutB);
endinterface

// File: rtl/reg_file_operand.sv
// Eight-entry operand register file (T1..T4, R1..R4) with masked clear/load/dec/inc
// updates and two independent zero-latency read ports.
module rf_reg #(
  parameter int NBits = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic [1:0]       fun_sel_i,
  input  logic [NBits-1:0] data_i,
  output logic [NBits-1:0] q_o
);
  logic [NBits-1:0] val_q, val_d;

  // Dec/inc wrap naturally through the fixed NBits width.
  always_comb begin
    val_d = val_q;
    if (en_i) begin
      unique case (fun_sel_i)
        2'b00: val_d = '0;
        2'b01: val_d = data_i;
        2'b10: val_d = val_q - NBits'(1);
        2'b11: val_d = val_q + NBits'(1);
        default: val_d = val_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q_o = val_q;
endmodule

module reg_file_operand #(
  parameter int NBits = 8
) (
  input logic                 CLK,
  input logic                 RST,
  reg_file_operand_if.slave   bus
);
  localparam int NUM_REGS = 8;

  // Storage index equals the select encoding: 0..3 = T1..T4, 4..7 = R1..R4.
  logic [NUM_REGS-1:0]            en;
  logic [NUM_REGS-1:0][NBits-1:0] regs;

  assign en = {bus.RSel, bus.TSel};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    rf_reg #(.NBits(NBits)) u_reg (
      .CLK       (CLK),
      .RST       (RST),
      .en_i      (en[g]),
      .fun_sel_i (bus.FunSel),
      .data_i    (bus.I),
      .q_o       (regs[g])
    );
  end

  assign bus.OutA = regs[bus.OutASel];
  assign bus.OutB = regs[bus.OutBSel];
endmodule

// File: tb/tb_reg_file_operand.sv
// Randomized + directed bench for reg_file_operand; expectations queued by stimulus,
// compared by an independent negedge monitor.
module tb_reg_file_operand;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  reg_file_operand_if #(.NBits(8)) bus ();

  reg_file_operand #(.NBits(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   model[8];

  // Monitor: one expectation per sampling point, taken mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (bus.OutA === e.a && bus.OutB === e.b) n_pass++;
      else $display("FAIL %s: OutA=%h OutB=%h required OutA=%h OutB=%h",
                    e.nm, bus.OutA, bus.OutB, e.a, e.b);
    end
  end

  function automatic void model_apply(input logic [3:0] rs, input logic [3:0] ts,
                                      input logic [1:0] fs, input logic [7:0] i);
    for (int k = 0; k < 8; k++) begin
      bit on;
      on = (k < 4) ? ts[k] : rs[k-4];
      if (on) begin
        case (fs)
          2'd0: model[k] = 0;
          2'd1: model[k] = int'(i);
          2'd2: model[k] = (model[k] + 255) % 256;
          2'd3: model[k] = (model[k] + 1) % 256;
        endcase
      end
    end
  endfunction

  // Entered just after a rising edge: drive, queue the pre-edge view, take the edge.
  task automatic cyc(input logic rst, input logic [3:0] rs, input logic [3:0] ts,
                     input logic [1:0] fs, input logic [7:0] i,
                     input logic [2:0] as, input logic [2:0] bs, input string nm);
    exp_t e;
    RST = rst; bus.RSel = rs; bus.TSel = ts; bus.FunSel = fs; bus.I = i;
    bus.OutASel = as; bus.OutBSel = bs;
    if (rst) for (int k = 0; k < 8; k++) model[k] = 0;
    e.nm = nm; e.a = 8'(model[as]); e.b = 8'(model[bs]);
    exp_q.push_back(e);
    @(posedge CLK);
    if (!rst) model_apply(rs, ts, fs, i);
    #1;
  endtask

  task automatic hold(input logic [2:0] as, input logic [2:0] bs, input string nm);
    cyc(1'b0, 4'h0, 4'h0, 2'($urandom_range(0, 3)), 8'($urandom), as, bs, nm);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) model[k] = 0;
    bus.I = 8'hA5; bus.FunSel = 2'b11; bus.RSel = 4'hF; bus.TSel = 4'hF;
    bus.OutASel = 3'd4; bus.OutBSel = 3'd0;
    @(posedge CLK); #1;

    cyc(1'b1, 4'hF, 4'hF, 2'd3, 8'h77, 3'd4, 3'd0, "reset_state");
    cyc(1'b0, 4'h1, 4'h0, 2'd1, 8'h5A, 3'd4, 3'd0, "r1_load_pre");
    for (int s = 0; s < 8; s++) hold(3'(s), 3'(7 - s), "r1_load_sweep");

    cyc(1'b0, 4'h2, 4'h0, 2'd1, 8'hFF, 3'd5, 3'd5, "r2_load");
    cyc(1'b0, 4'h2, 4'h0, 2'd3, 8'h00, 3'd5, 3'd5, "r2_inc_pre_ff");
    cyc(1'b0, 4'h2, 4'h0, 2'd3, 8'h00, 3'd0, 3'd5, "r2_inc_wrap_00");
    hold(3'd1, 3'd5, "r2_inc_01");

    cyc(1'b0, 4'h0, 4'h4, 2'd2, 8'h12, 3'd2, 3'd2, "t3_dec_pre");
    hold(3'd2, 3'd6, "t3_dec_wrap_ff");

    cyc(1'b0, 4'hF, 4'hF, 2'd1, 8'h3C, 3'd0, 3'd7, "load_all");
    for (int s = 0; s < 8; s++) hold(3'(s), 3'(7 - s), "load_all_sweep");
    cyc(1'b0, 4'h0, 4'h0, 2'd0, 8'h00, 3'd3, 3'd4, "zero_mask_clear");
    for (int s = 0; s < 8; s++) hold(3'(7 - s), 3'(s), "noop_sweep");

    cyc(1'b0, 4'h8, 4'h0, 2'd1, 8'h10, 3'd7, 3'd7, "r4_load");
    cyc(1'b0, 4'h8, 4'h0, 2'd3, 8'h99, 3'd7, 3'd7, "r4_same_sel_pre");
    hold(3'd7, 3'd7, "r4_same_sel_post");

    cyc(1'b0, 4'h1, 4'h0, 2'd1, 8'h22, 3'd4, 3'd4, "r1_load_22");
    hold(3'd4, 3'd0, "r1_is_22");
    cyc(1'b1, 4'h1, 4'h0, 2'd3, 8'h00, 3'd4, 3'd7, "rst_async_drop");
    cyc(1'b1, 4'h1, 4'h0, 2'd1, 8'hEE, 3'd4, 3'd0, "rst_blocks_edge");
    cyc(1'b0, 4'h1, 4'h0, 2'd3, 8'h00, 3'd4, 3'd5, "post_rst_pre");
    hold(3'd4, 3'd6, "post_rst_inc");

    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 24) == 0);
      cyc(r, 4'($urandom), 4'($urandom), 2'($urandom), 8'($urandom),
          3'($urandom), 3'($urandom), "random");
    end
    RST = 1'b0; bus.RSel = 4'h0; bus.TSel = 4'h0;

    @(negedge CLK); #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_file_operand.md
REG_FILE_OPERAND -- requirements
Module: reg_file_operand

Interface
REQ-001 Parameter: NBits, 8, width of every register and of both operand outputs.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: I  input  NBits  write data for load operations.
REQ-005 Port: FunSel  input  2  operation applied to enabled registers: 00 clear, 01 load I, 10 decrement, 11 increment.
REQ-006 Port: RSel  input  4  enable mask for general registers R1..R4; bit0=R1 ... bit3=R4; 1 = enabled.
REQ-007 Port: TSel  input  4  enable mask for temporary registers T1..T4; bit0=T1 ... bit3=T4; 1 = enabled.
REQ-008 Port: OutASel  input  3  source select for OutA: 000..011 = T1..T4, 100..111 = R1..R4.
REQ-009 Port: OutBSel  input  3  source select for OutB, same encoding as OutASel.
REQ-010 Port: OutA  output  NBits  operand A, feeds the ALU A input.
REQ-011 Port: OutB  output  NBits  operand B, feeds the ALU B input.

Function
REQ-012 The block SHALL hold eight NBits registers: R1..R4 and T1..T4.
REQ-013 On each rising CLK edge with RST low, every register whose mask bit is 1 SHALL apply FunSel; registers with mask bit 0 SHALL hold.
REQ-014 Clear (00): the register SHALL become 0.
REQ-015 Load (01): the register SHALL become I; multiple enabled registers all load the same I in the same cycle.
REQ-016 Decrement (10): the register SHALL become value-1 modulo 2^NBits; 0x00 wraps to 0xFF with no flag or side effect.
REQ-017 Increment (11): the register SHALL become value+1 modulo 2^NBits; 0xFF wraps to 0x00 with no flag or side effect.
REQ-018 OutA and OutB SHALL be combinational functions of the current register contents and OutASel/OutBSel; zero-cycle read latency.
REQ-019 Read during write: an output selecting a register updated on an edge SHALL show the pre-edge value before that edge and the new value after it; no bypass of I.
REQ-020 OutASel and OutBSel SHALL be independent; both selecting the same register SHALL yield identical OutA and OutB.
REQ-021 All-zero masks SHALL be a full no-op regardless of FunSel and I.
REQ-022 Every register SHALL be updated by one shared per-register update stage (mask bit, FunSel, I); no register has special behaviour.
REQ-023 No X SHALL propagate to OutA/OutB for any legal select value; all 3-bit select encodings are legal.

Reset
REQ-024 RST high SHALL immediately, without a CLK edge, clear all eight registers to 0; OutA and OutB SHALL read 0 at any select.
REQ-025 While RST is high, CLK edges SHALL have no effect, including enabled increments and loads.
REQ-026 RST asserted mid-sequence (e.g. between two increments) SHALL discard the in-flight operation; the first edge after RST deassertion applies FunSel to the cleared values.
REQ-027 After reset, no register SHALL hold a value other than 0 until an enabled edge occurs.

Verification
REQ-028 Reset, then RSel=0001, TSel=0000, FunSel=01, I=0x5A, one edge, OutASel=100 -> OutA=0x5A; all other registers read 0x00.
REQ-029 R2 loaded 0xFF, RSel=0010, FunSel=11, one edge, OutBSel=101 -> OutB=0x00; second edge -> 0x01.
REQ-030 T3 at 0x00, TSel=0100, FunSel=10, one edge, OutASel=010 -> OutA=0xFF.
REQ-031 RSel=1111, TSel=1111, FunSel=01, I=0x3C, one edge -> all eight registers read 0x3C via sweeps of OutASel and OutBSel; then RSel=TSel=0000, FunSel=00, edge -> all still 0x3C.
REQ-032 R4=0x10, OutASel=OutBSel=111, RSel=1000, FunSel=11: before edge OutA=OutB=0x10, after edge OutA=OutB=0x11.
REQ-033 R1=0x22, assert RST between edges with no CLK -> OutA (OutASel=100) drops to 0x00 asynchronously; an increment edge during RST leaves 0x00; first edge after release with FunSel=11, RSel=0001 -> 0x01.
